fp_sub_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 34 +++
 rtl/fp_norm_step.sv | 44 ++++
 rtl/fp_sub_seq.sv | 169 ++++++++++++++++
 tb/tb_fp_sub_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FP arithmetic unit: format widths,
// sequencer state encoding and the field-unpack helper.
package fp_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SIG_W  = 24;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SWAP   = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_ARITH  = 3'd3,
    ST_NORM   = 3'd4,
    ST_FINISH = 3'd5
  } fp_seq_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_fields_t;

  function automatic fp_fields_t fp_unpack(input logic [FP_W-1:0] v);
    fp_fields_t f;
    f.sign = v[FP_W-1];
    f.exp  = v[FP_W-2:MANT_W];
    f.mant = v[MANT_W-1:0];
    return f;
  endfunction

endpackage

// File: rtl/fp_norm_step.sv
// Combinational single-step normaliser: at most one shift of the 25-bit
// significand per call. underflow means "flush the result to +0".
module fp_norm_step
  import fp_pkg::*;
(
  input  logic [SIG_W:0]   sig_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic [SIG_W:0]   sig_nxt,
  output logic [EXP_W-1:0] exp_nxt,
  output logic             finished,
  output logic             overflow,
  output logic             underflow
);

  // priority: carry, zero, already normal, otherwise one left shift
  always_comb begin
    sig_nxt   = sig_in;
    exp_nxt   = exp_in;
    finished  = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (sig_in[SIG_W]) begin
      sig_nxt  = {1'b0, sig_in[SIG_W:1]};
      exp_nxt  = exp_in + 8'd1;
      finished = 1'b1;
      overflow = (exp_in >= EXP_MAX);
    end else if (sig_in == {(SIG_W+1){1'b0}}) begin
      finished  = 1'b1;
      underflow = 1'b1;
    end else if (sig_in[SIG_W-1]) begin
      finished = 1'b1;
    end else begin
      sig_nxt = {sig_in[SIG_W-1:0], 1'b0};
      exp_nxt = exp_in - 8'd1;
      if (exp_in <= 8'd1) begin
        finished  = 1'b1;
        underflow = 1'b1;
      end else begin
        finished = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle binary32 subtractor (dataa - datab) with enable/done handshake.
// Alignment and normalisation proceed one bit per clock.
module fp_sub_seq
  import fp_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [FP_W-1:0] dataa,
  input  logic [FP_W-1:0] datab,
  output logic [FP_W-1:0] result,
  output logic            done
);

  fp_seq_state_t     state_r, state_s;
  logic [FP_W-1:0]   a_r, b_r;
  logic [SIG_W:0]    sig_big_r;
  logic [SIG_W-1:0]  sig_small_r;
  logic [EXP_W-1:0]  exp_r;
  logic              sign_r, sub_r;
  logic [4:0]        d_r;
  logic [FP_W-1:0]   result_r, result_s;
  logic              done_r, done_s;
  fp_fields_t        fb_s, ca_s, cb_s;
  logic              zero_rule_s, a_big_s;
  logic [FP_W-1:0]   zero_res_s;
  logic [EXP_W-1:0]  ediff_s;
  logic [SIG_W:0]    norm_sig_s;
  logic [EXP_W-1:0]  norm_exp_s;
  logic              norm_fin_s, norm_ovf_s, norm_unf_s;

  assign fb_s = fp_unpack(datab);
  assign ca_s = fp_unpack(a_r);
  assign cb_s = fp_unpack(b_r);

  assign zero_rule_s = (dataa[FP_W-2:MANT_W] == 8'd0) || (fb_s.exp == 8'd0);

  // result for operands caught by the zero rule (denormals count as zero)
  always_comb begin
    zero_res_s = 32'h0000_0000;
    if ((dataa[FP_W-2:MANT_W] == 8'd0) && (fb_s.exp == 8'd0)) begin
      zero_res_s = 32'h0000_0000;
    end else if (fb_s.exp == 8'd0) begin
      zero_res_s = dataa;
    end else begin
      zero_res_s = {~fb_s.sign, fb_s.exp, fb_s.mant};
    end
  end

  // on an exact tie b is the big operand, so the difference is never negative
  assign a_big_s = (ca_s.exp > cb_s.exp) ||
                   ((ca_s.exp == cb_s.exp) && (ca_s.mant > cb_s.mant));
  assign ediff_s = a_big_s ? (ca_s.exp - cb_s.exp) : (cb_s.exp - ca_s.exp);

  fp_norm_step u_norm (
    .sig_in    (sig_big_r),
    .exp_in    (exp_r),
    .sig_nxt   (norm_sig_s),
    .exp_nxt   (norm_exp_s),
    .finished  (norm_fin_s),
    .overflow  (norm_ovf_s),
    .underflow (norm_unf_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // next-state logic; a completing NORM step returns straight to IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_s = zero_rule_s ? ST_FINISH : ST_SWAP;
        else        state_s = ST_IDLE;
      end
      ST_SWAP:   state_s = (ediff_s == 8'd0) ? ST_ARITH : ST_ALIGN;
      ST_ALIGN:  state_s = (d_r == 5'd1) ? ST_ARITH : ST_ALIGN;
      ST_ARITH:  state_s = ST_NORM;
      ST_NORM:   state_s = norm_fin_s ? ST_IDLE : ST_NORM;
      ST_FINISH: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // completion outputs: pack the normaliser result or forward the preload
  always_comb begin
    done_s   = 1'b0;
    result_s = result_r;
    case (state_r)
      ST_NORM: begin
        if (norm_fin_s) begin
          done_s = 1'b1;
          if (norm_ovf_s)      result_s = {sign_r, 8'hFF, 23'h0};
          else if (norm_unf_s) result_s = 32'h0000_0000;
          else                 result_s = {sign_r, norm_exp_s, norm_sig_s[MANT_W-1:0]};
        end else begin
          done_s = 1'b0;
        end
      end
      ST_FINISH: begin
        done_s   = 1'b1;
        result_s = a_r;
      end
      default: done_s = 1'b0;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      done_r   <= 1'b0;
      result_r <= 32'h0000_0000;
    end else begin
      done_r   <= done_s;
      result_r <= result_s;
    end
  end

  // datapath; a_r doubles as the preloaded result on the zero-rule path
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r         <= 32'h0000_0000;
      b_r         <= 32'h0000_0000;
      sig_big_r   <= 25'h0;
      sig_small_r <= 24'h0;
      exp_r       <= 8'h00;
      sign_r      <= 1'b0;
      sub_r       <= 1'b0;
      d_r         <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (enable) begin
            a_r <= zero_rule_s ? zero_res_s : dataa;
            b_r <= datab;
          end
        end
        ST_SWAP: begin
          sig_big_r   <= {1'b0, 1'b1, (a_big_s ? ca_s.mant : cb_s.mant)};
          sig_small_r <= {1'b1, (a_big_s ? cb_s.mant : ca_s.mant)};
          exp_r       <= a_big_s ? ca_s.exp : cb_s.exp;
          sign_r      <= a_big_s ? ca_s.sign : ~cb_s.sign;
          sub_r       <= (ca_s.sign == cb_s.sign);
          d_r         <= (ediff_s >= 8'd25) ? 5'd25 : ediff_s[4:0];
        end
        ST_ALIGN: begin
          sig_small_r <= {1'b0, sig_small_r[SIG_W-1:1]};
          d_r         <= d_r - 5'd1;
        end
        ST_ARITH: begin
          sig_big_r <= sub_r ? (sig_big_r - {1'b0, sig_small_r})
                             : (sig_big_r + {1'b0, sig_small_r});
        end
        ST_NORM: begin
          sig_big_r <= norm_sig_s;
          exp_r     <= norm_exp_s;
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;
  assign done   = done_r;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed vectors, control scenarios and
// randomized operands against an arithmetic reference model.
module tb_fp_sub_seq;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [31:0] result;
  logic        done;

  int n_checks;
  int n_fail;

  fp_sub_seq dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .dataa  (dataa),
    .datab  (datab),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: zero rule, then align/add-or-subtract/normalise with truncation.
  function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
    int ea, eb, eg, es, d, e, shifts;
    longint ma, mb, mg, ms, s;
    logic sa, sb, sg, ss, fin;
    logic [7:0] e8;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = ~b[31];
    lat = 1;
    r = 32'h0;
    if (ea == 0 && eb == 0) return;
    if (eb == 0) begin r = a; return; end
    if (ea == 0) begin r = {sb, b[30:0]}; return; end
    ma = (longint'(1) << 23) + longint'(a[22:0]);
    mb = (longint'(1) << 23) + longint'(b[22:0]);
    if (ea > eb || (ea == eb && ma > mb)) begin
      eg = ea; es = eb; mg = ma; ms = mb; sg = sa; ss = sb;
    end else begin
      eg = eb; es = ea; mg = mb; ms = ma; sg = sb; ss = sa;
    end
    d = eg - es;
    if (d > 25) d = 25;
    ms = ms >> d;
    s = (sg == ss) ? mg + ms : mg - ms;
    e = eg;
    shifts = 0;
    if (s >= (longint'(1) << 24)) begin
      if (e + 1 > 254) r = {sg, 8'hFF, 23'h0};
      else begin
        s = s >> 1;
        e = e + 1;
        e8 = e[7:0];
        r = {sg, e8, s[22:0]};
      end
    end else begin
      fin = 1'b0;
      while (!fin) begin
        if (s == 0) begin r = 32'h0; fin = 1'b1; end
        else if (s >= (longint'(1) << 23)) begin
          e8 = e[7:0];
          r = {sg, e8, s[22:0]};
          fin = 1'b1;
        end else if (e == 1) begin r = 32'h0; fin = 1'b1; end
        else begin s = s << 1; e = e - 1; shifts = shifts + 1; end
      end
    end
    lat = 3 + d + shifts;
  endfunction

  // Issue one operation from IDLE; returns at the sample point of the done cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat);
    @(negedge clk);
    enable = 1'b1;
    dataa  = a;
    datab  = b;
    @(posedge clk);
    #1;
    enable = 1'b0;
    dataa  = $urandom;
    datab  = $urandom;
    lat = 0;
    r   = 32'h0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        r   = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    enable = 1'b0;
    dataa = 32'h0;
    datab = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
    // enable coinciding with reset must be dropped
    enable = 1'b1;
    dataa = 32'h4000_0000;
    datab = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    enable = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL reset_wins: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [0:11] = '{32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
                               32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'h0080_0001,
                               32'h7F7F_FFFF, 32'h0000_0000, 32'h3F80_0000, 32'hC000_0000};
    logic [31:0] tb [0:11] = '{32'h3F80_0000, 32'hBF80_0000, 32'h3F40_0000, 32'h3F80_0000,
                               32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0080_0000,
                               32'hFF7F_FFFF, 32'hC040_0000, 32'h3F7F_FFFF, 32'hC000_0000};
    logic [31:0] tr [0:11] = '{32'h4000_0000, 32'h4000_0000, 32'h3E80_0000, 32'h0000_0000,
                               32'hC000_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000,
                               32'h7F80_0000, 32'h4040_0000, 32'h3400_0000, 32'h0000_0000};
    int tl [0:11] = '{4, 3, 6, 3, 1, 1, 1, 3, 3, 1, 27, 3};
    logic [31:0] r;
    int lat;
    for (int i = 0; i < 12; i++) begin
      issue(ta[i], tb[i], r, lat);
      n_checks++;
      if (r !== tr[i]) begin n_fail++; $display("FAIL directed[%0d] result: got %h expected %h", i, r, tr[i]); end
      n_checks++;
      if (lat !== tl[i]) begin n_fail++; $display("FAIL directed[%0d] latency: got %0d expected %0d", i, lat, tl[i]); end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL directed[%0d] done_width: got %b expected 0", i, done); end
      n_checks++;
      if (result !== tr[i]) begin n_fail++; $display("FAIL directed[%0d] result_hold: got %h expected %h", i, result, tr[i]); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] er, r;
    int el, first, cnt;
    ref_sub(32'h4B80_0000, 32'h3F80_0000, er, el);
    @(negedge clk);
    enable = 1'b1;
    dataa = 32'h4B80_0000;
    datab = 32'h3F80_0000;
    @(posedge clk);
    #1;
    first = 0;
    cnt = 0;
    r = 32'h0;
    for (int i = 1; i <= 60; i++) begin
      enable = (i >= 2) && (i <= 12) && (i % 2 == 0);
      dataa = 32'h0;
      datab = 32'h3F80_0000;
      @(posedge clk);
      #1;
      if (done) begin
        cnt++;
        if (first == 0) begin first = i; r = result; end
      end
    end
    enable = 1'b0;
    n_checks++;
    if (first !== el) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", first, el); end
    n_checks++;
    if (r !== er) begin n_fail++; $display("FAIL busy_result: got %h expected %h", r, er); end
    n_checks++;
    if (cnt !== 1) begin n_fail++; $display("FAIL busy_ignore: got %0d done pulses expected 1", cnt); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    enable = 1'b1;
    dataa = 32'h4B80_0000;
    datab = 32'h3F80_0000;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result: got %h expected 00000000", result); end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_discard: got %0d done pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    int lat;
    issue(32'h0000_0000, 32'h3F80_0000, r, lat);
    n_checks++;
    if (r !== 32'hBF80_0000 || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_first: got %h lat %0d expected bf800000 lat 1", r, lat);
    end
    // still inside the done cycle: request the next operation immediately
    enable = 1'b1;
    dataa = 32'h4040_0000;
    datab = 32'h3F80_0000;
    @(posedge clk);
    #1;
    enable = 1'b0;
    lat = 0;
    r = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin lat = i; r = result; break; end
    end
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    n_checks++;
    if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL b2b_result: got %h expected 40000000", r); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, er, r;
    int el, lat, e;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: b[30:23] = a[30:23];
        2: begin
          e = int'(a[30:23]) + int'($urandom_range(0, 6)) - 3;
          if (e < 0) e = 0;
          if (e > 255) e = 255;
          b[30:23] = e[7:0];
        end
        3: b = a ^ {9'h000, 23'($urandom_range(0, 255))};
        default: begin
          if ($urandom_range(0, 1) == 1) a[30:23] = 8'h00;
          else b[30:23] = 8'h00;
        end
      endcase
      ref_sub(a, b, er, el);
      issue(a, b, r, lat);
      n_checks++;
      if (r !== er) begin n_fail++; $display("FAIL random[%0d] result %h-%h: got %h expected %h", n, a, b, r, er); end
      n_checks++;
      if (lat !== el) begin n_fail++; $display("FAIL random[%0d] latency %h-%h: got %0d expected %0d", n, a, b, lat, el); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset  = 1'b1;
    enable = 1'b0;
    dataa  = 32'h0;
    datab  = 32'h0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
